// File: rtl/instr_fetch_cache.sv
// Direct-mapped instruction cache serving 32-bit words to the IF stage.
// Misses refill a whole line from backing memory over a req/ack burst.
module instr_fetch_cache #(
   parameter int INDEX_BITS  = 4,
   parameter int OFFSET_BITS = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_hit,
   output logic [31:0]       if_instr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic [15:0]       miss_count
);

   localparam int LINES   = 1 << INDEX_BITS;
   localparam int WORDS   = 1 << OFFSET_BITS;
   localparam int LSB     = OFFSET_BITS + 2;
   localparam int TAG_LSB = LSB + INDEX_BITS;
   localparam int TAG_W   = ADDR_W - TAG_LSB;
   localparam int LINE_W  = ADDR_W - LSB;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] REFILL    = 2'd1;
   localparam logic [1:0] FILL_DONE = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [LINES-1:0]       valid_q;
   logic [TAG_W-1:0]       tag_q  [LINES];
   logic [31:0]            data_q [LINES][WORDS];
   logic [LINE_W-1:0]      line_q;
   logic [OFFSET_BITS-1:0] k_q;
   logic [15:0]            miss_q;

   logic [INDEX_BITS-1:0]  idx;
   logic [TAG_W-1:0]       tag;
   logic [OFFSET_BITS-1:0] off;
   logic [INDEX_BITS-1:0]  fill_idx;
   logic [TAG_W-1:0]       fill_tag;
   logic                   lookup_hit;
   logic                   miss;
   logic                   ack;
   logic                   last;
   logic                   unused_addr_bits;

   assign idx      = if_addr[TAG_LSB-1:LSB];
   assign tag      = if_addr[ADDR_W-1:TAG_LSB];
   assign off      = if_addr[LSB-1:2];
   assign fill_idx = line_q[INDEX_BITS-1:0];
   assign fill_tag = line_q[LINE_W-1:INDEX_BITS];
   assign unused_addr_bits = ^if_addr[1:0];

   // No hit-under-miss: lookups only answer while idle.
   assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
   assign if_hit     = if_req && (state_q == IDLE) && lookup_hit;
   assign if_instr   = if_hit ? data_q[idx][off] : 32'b0;
   assign miss       = if_req && (state_q == IDLE) && !lookup_hit;

   assign mem_req    = (state_q == REFILL);
   assign mem_addr   = mem_req ? {line_q, k_q, 2'b00} : '0;
   assign ack        = mem_req && mem_ack;
   assign last       = ack && (k_q == '1);
   assign miss_count = miss_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (miss) state_d = REFILL;
         REFILL:    if (last) state_d = FILL_DONE;
         FILL_DONE: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         line_q  <= '0;
         k_q     <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         if (miss) begin
            line_q <= if_addr[ADDR_W-1:LSB];
            k_q    <= '0;
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
         end
         if (ack) k_q <= k_q + OFFSET_BITS'(1);
         if (last) valid_q[fill_idx] <= 1'b1;
      end
   end

   // Payload arrays carry no reset; valid bits alone gate their use.
   always_ff @(posedge clk) begin
      if (ack) data_q[fill_idx][k_q] <= mem_rdata;
      if (last) tag_q[fill_idx] <= fill_tag;
   end

endmodule
